spi_command_host: RTL

//  Initiator side of the byte-wide SPI command link: turns single-beat requests (register write,

---
 rtl/spi_cmd_pkg.sv | 36 +++
 rtl/spi_command_host.sv | 125 ++++++++++++
 2 files changed

// File: rtl/spi_cmd_pkg.sv
// ----------------------------------------------------------------------------
// spi_cmd_pkg : command bytes, op encodings and FSM states shared by the
//               SPI command host and the character-match responder.
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package spi_cmd_pkg;

  localparam logic [7:0] CMD_WRITE        = 8'h02;
  localparam logic [7:0] CMD_READ         = 8'h03;
  localparam logic [7:0] CMD_STREAM       = 8'h80;
  localparam logic [7:0] NOP_BYTE_DEFAULT = 8'h00;

  localparam logic [1:0] OP_WRITE   = 2'b00;
  localparam logic [1:0] OP_READ    = 2'b01;
  localparam logic [1:0] OP_STREAM  = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  localparam int ARG_RESULT_SEL = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARG  = 3'd1,
    ST_DATA = 3'd2,
    ST_WAIT = 3'd3,
    ST_CAPT = 3'd4
  } state_e;

  function automatic logic [7:0] arg_byte(input logic [4:0] addr);
    return {3'b000, addr};
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_command_host.sv
// ----------------------------------------------------------------------------
// spi_command_host : turns single-beat requests into CMD/ARG/DATA byte
//                    sequences on mosi and captures miso for reads.
// Revision         : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spi_command_host
  import spi_cmd_pkg::*;
#(
  parameter logic [7:0] NOP_BYTE = NOP_BYTE_DEFAULT
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [4:0] req_addr,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       req_err,
  output logic       cs,
  output logic [7:0] mosi,
  input  logic [7:0] miso,
  output logic       busy
);

  state_e     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [4:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] mosi_q, mosi_d;
  logic       cs_q, cs_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       req_err_q, req_err_d;

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_WRITE;
      addr_q      <= '0;
      data_q      <= '0;
      mosi_q      <= NOP_BYTE;
      cs_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      req_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      mosi_q      <= mosi_d;
      cs_q        <= cs_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      req_err_q   <= req_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    mosi_d      = NOP_BYTE;
    cs_d        = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    req_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          // Request fields are frozen here; later input changes are ignored.
          op_d   = req_op;
          addr_d = req_addr;
          data_d = req_data;
          case (req_op)
            OP_WRITE:  begin mosi_d = CMD_WRITE;  cs_d = 1'b1; state_d = ST_ARG; end
            OP_READ:   begin mosi_d = CMD_READ;   cs_d = 1'b1; state_d = ST_ARG; end
            OP_STREAM: begin mosi_d = CMD_STREAM; cs_d = 1'b1; state_d = ST_ARG; end
            default:   req_err_d = 1'b1;
          endcase
        end
      end
      ST_ARG: begin
        cs_d = 1'b1;
        if (op_q == OP_STREAM) begin
          // Stream carries its byte directly after the command, no ARG.
          mosi_d  = data_q;
          state_d = ST_IDLE;
        end else begin
          mosi_d  = arg_byte(addr_q);
          state_d = (op_q == OP_WRITE) ? ST_DATA : ST_WAIT;
        end
      end
      ST_DATA: begin
        mosi_d  = data_q;
        cs_d    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_WAIT: state_d = ST_CAPT;
      ST_CAPT: begin
        rsp_data_d  = miso;
        rsp_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign mosi      = mosi_q;
  assign cs        = cs_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign req_err   = req_err_q;

endmodule

`default_nettype wire
